// File: rtl/from_hex.sv
// Receive-path ASCII-hex decoder: pops characters from the RX queue, pairs hex
// digits into bytes and holds each byte on out_data/out_en until out_ack.
module from_hex (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_ack,
    output logic [7:0] out_data,
    output logic       out_en,
    input  logic       out_ack,
    output logic       bad_char,
    output logic [7:0] bad_count
);

    typedef enum logic {IDLE, HIGH} state_t;

    state_t     state;
    logic [3:0] hi;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_digit(c) ||
               ((c >= 8'h61) && (c <= 8'h66)) ||
               ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic is_sep(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);
    endfunction

    // Letters a-f / A-F both have low nibble 1..6, so +9 maps them to 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return is_digit(c) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    logic       hex_c;
    logic       sep_c;
    logic       emit;
    logic       accept;
    logic [3:0] val;

    always_comb begin
        hex_c  = is_hex(rx_data);
        sep_c  = is_sep(rx_data);
        val    = hex_val(rx_data);
        emit   = (state == HIGH) && (hex_c || sep_c);
        // rx_ack high marks the recovery cycle; emitting chars wait for a free output
        accept = rx_rdy && !rx_ack && (!emit || !out_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            hi        <= 4'h0;
            rx_ack    <= 1'b0;
            out_en    <= 1'b0;
            out_data  <= 8'h00;
            bad_char  <= 1'b0;
            bad_count <= 8'h00;
        end else begin
            rx_ack   <= accept;
            bad_char <= 1'b0;
            if (out_en && out_ack)
                out_en <= 1'b0;
            if (accept) begin
                if (hex_c) begin
                    if (state == IDLE) begin
                        hi    <= val;
                        state <= HIGH;
                    end else begin
                        out_data <= {hi, val};
                        out_en   <= 1'b1;
                        state    <= IDLE;
                    end
                end else if (sep_c) begin
                    if (state == HIGH) begin
                        out_data <= {4'h0, hi};
                        out_en   <= 1'b1;
                        state    <= IDLE;
                    end
                end else begin
                    bad_char <= 1'b1;
                    if (bad_count != 8'hFF)
                        bad_count <= bad_count + 8'd1;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_from_hex.sv
// Scoreboard bench for from_hex: a queue model feeds characters, a monitor
// compares each newly presented byte against the expected-byte queue.
module tb_from_hex;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_ack;
    logic [7:0] out_data;
    logic       out_en;
    logic       out_ack;
    logic       bad_char;
    logic [7:0] bad_count;

    always #5 clk = ~clk;

    from_hex dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
        .out_data(out_data), .out_en(out_en), .out_ack(out_ack),
        .bad_char(bad_char), .bad_count(bad_count)
    );

    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_total = 0;
    int last_ack = -100;
    int min_gap = 1000;
    int bad_pulses = 0;
    int en_cycles = 0;
    logic prev_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RX queue model: pop happens on the edge ending an rx_ack cycle
    initial forever begin
        @(negedge clk);
        if (rx_ack === 1'b1) begin
            ack_total++;
            if (cyc - last_ack < min_gap) min_gap = cyc - last_ack;
            last_ack = cyc;
            if (rxq.size() > 0) void'(rxq.pop_front());
        end
        rx_rdy  = (rxq.size() > 0);
        rx_data = rx_rdy ? rxq[0] : 8'h00;
    end

    // Monitor: each 0->1 transition of out_en presents a new byte
    initial forever begin
        @(negedge clk);
        if (out_en === 1'b1) en_cycles++;
        if (bad_char === 1'b1) bad_pulses++;
        if (out_en === 1'b1 && !prev_en) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none", out_data);
            end else begin
                check("byte", {24'h0, out_data}, {24'h0, expq.pop_front()});
            end
        end
        prev_en = (out_en === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
    endtask

    task automatic wait_q(input int budget);
        int n = 0;
        @(negedge clk);
        while ((rxq.size() > 0 || rx_ack === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain_in_budget", (n < budget), 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        wait_q(budget);
        while ((expq.size() > 0 || out_en === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("output_drain_in_budget", (n < budget), 1);
    endtask

    task automatic check_reset_vals();
        check("rst_rx_ack", rx_ack, 0);
        check("rst_out_en", out_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_bad_char", bad_char, 0);
        check("rst_bad_count", bad_count, 0);
    endtask

    int a0, e0, b0;

    initial begin
        rst = 1'b0;
        out_ack = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;

        // "41" with out_ack tied high
        a0 = ack_total; e0 = en_cycles; min_gap = 1000;
        expq.push_back(8'h41);
        push_str("41");
        drain(100);
        check("t1_ack_pulses", ack_total - a0, 2);
        check("t1_ack_spacing_ge2", (min_gap >= 2), 1);
        check("t1_en_cycles", en_cycles - e0, 1);

        // "aF 7\n": trailing separator after aF yields no byte
        e0 = en_cycles;
        expq.push_back(8'hAF);
        expq.push_back(8'h07);
        push_str("aF 7");
        rxq.push_back(8'h0A);
        drain(100);
        check("t2_en_cycles", en_cycles - e0, 2);

        // "3g55": g drops the pending 3
        b0 = bad_pulses;
        expq.push_back(8'h55);
        push_str("3g55");
        drain(100);
        check("t3_bad_pulses", bad_pulses - b0, 1);
        check("t3_bad_count", bad_count, 1);

        // Stall: out_ack low, 0x12 held, 3 consumed, 4 stalls
        out_ack = 1'b0;
        expq.push_back(8'h12);
        expq.push_back(8'h34);
        push_str("1234");
        repeat (40) @(negedge clk);
        a0 = ack_total;
        repeat (20) @(negedge clk);
        check("t4_no_ack_while_stalled", ack_total - a0, 0);
        check("t4_rx_rdy", rx_rdy, 1);
        check("t4_queue_left", rxq.size(), 1);
        check("t4_out_en_held", out_en, 1);
        check("t4_out_data_held", out_data, 8'h12);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("t4_out_en_fell", out_en, 0);
        wait_q(100);
        check("t4_out_en_34", out_en, 1);
        check("t4_out_data_34", out_data, 8'h34);
        out_ack = 1'b1;
        drain(100);

        // 300 bad characters: counter saturates, every one pulses
        b0 = bad_pulses;
        for (int i = 0; i < 300; i++) rxq.push_back(8'h7A);
        drain(2000);
        check("t5_bad_pulses", bad_pulses - b0, 300);
        check("t5_bad_count_sat", bad_count, 255);

        // Reset with 9 pending and out_en high
        out_ack = 1'b0;
        expq.push_back(8'h12);
        push_str("12");
        wait_q(100);
        push_str("9");
        wait_q(100);
        check("t6_out_en_before_rst", out_en, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_vals();
        out_ack = 1'b1;
        expq.push_back(8'h01);
        push_str("01");
        drain(100);
        check("end_expq_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
